// File: rtl/ssp_uart_fifo.sv
// First-word-fall-through FIFO behind the SSP UART TDR/RDR registers: occupancy,
// fill threshold, sticky overflow/underflow flags and a registered maskable interrupt.
module ssp_uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Clr,
    input  logic          WE,
    input  logic [DW-1:0] DI,
    input  logic          RE,
    output logic [DW-1:0] DO,
    input  logic [AW:0]   Thr,
    output logic [AW:0]   Count,
    output logic          EF,
    output logic          FF,
    output logic          HF,
    output logic          TF,
    output logic          OVR,
    output logic          UNR,
    input  logic          ErrClr,
    input  logic [3:0]    IrqEn,
    output logic          IRQ
);
    localparam int          DEPTH_I = 1 << AW;
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] HALF    = DEPTH >> 1;

    logic [DW-1:0] mem [DEPTH_I];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          ovr;
    logic          unr;
    logic          irq_p1;

    logic          wr_ok;
    logic          rd_ok;
    logic          ovr_ev;
    logic          unr_ev;
    logic [3:0]    irq_src;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge
    assign wr_ok  = WE && ((cnt != DEPTH) || RE);
    assign rd_ok  = RE && (cnt != '0);
    assign ovr_ev = WE && (cnt == DEPTH) && !RE;
    assign unr_ev = RE && (cnt == '0);

    assign Count = cnt;
    assign EF    = (cnt == '0);
    assign FF    = (cnt == DEPTH);
    assign HF    = (cnt >= HALF);
    assign TF    = (Thr != '0) && (cnt >= Thr);
    assign OVR   = ovr;
    assign UNR   = unr;
    assign IRQ   = irq_p1;
    assign DO    = mem[rp];

    assign irq_src = {ovr | unr, TF, HF, EF};

    // Storage array carries no reset; contents are qualified by the pointers
    always_ff @(posedge Clk) begin
        if (!Clr && wr_ok) begin
            mem[wp] <= DI;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
            unr    <= 1'b0;
            irq_p1 <= 1'b0;
        end else if (Clr) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
            unr    <= 1'b0;
            irq_p1 <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp <= wp + AW'(1);
            end
            if (rd_ok) begin
                rp <= rp + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            // A fresh error on this edge takes precedence over ErrClr
            if (ovr_ev) begin
                ovr <= 1'b1;
            end else if (ErrClr) begin
                ovr <= 1'b0;
            end
            if (unr_ev) begin
                unr <= 1'b1;
            end else if (ErrClr) begin
                unr <= 1'b0;
            end
            // Stage p1: interrupt request registered from pre-edge status
            irq_p1 <= |(IrqEn & irq_src);
        end
    end
endmodule

// File: tb/tb_ssp_uart_fifo.sv
// Scoreboard bench for ssp_uart_fifo (DW=8, AW=4): queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_ssp_uart_fifo;
    localparam int D = 16;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Clr;
    logic       WE;
    logic [7:0] DI;
    logic       RE;
    logic [7:0] DO;
    logic [4:0] Thr;
    logic [4:0] Count;
    logic       EF, FF, HF, TF, OVR, UNR;
    logic       ErrClr;
    logic [3:0] IrqEn;
    logic       IRQ;

    ssp_uart_fifo #(.DW(8), .AW(4)) dut (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .WE(WE), .DI(DI), .RE(RE), .DO(DO),
        .Thr(Thr), .Count(Count), .EF(EF), .FF(FF), .HF(HF), .TF(TF),
        .OVR(OVR), .UNR(UNR), .ErrClr(ErrClr), .IrqEn(IrqEn), .IRQ(IRQ)
    );

    always #5 Clk = ~Clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit         m_ovr = 0;
    bit         m_unr = 0;
    bit         m_irq = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance one clock edge using the pre-edge state
    task automatic model_edge(input bit we, input bit re, input logic [7:0] di,
                              input bit clr, input bit eclr);
        int n;
        bit ef, ff, hf, tf;
        n  = mq.size();
        ef = (n == 0);
        ff = (n == D);
        hf = (n >= D / 2);
        tf = (Thr != 0) && (n >= int'(Thr));
        if (clr) begin
            mq.delete();
            m_ovr = 0;
            m_unr = 0;
            m_irq = 0;
        end else begin
            m_irq = |(IrqEn & {m_ovr | m_unr, tf, hf, ef});
            if (re && n > 0) void'(mq.pop_front());
            if (we && (n < D || re)) mq.push_back(di);
            if (we && n == D && !re) m_ovr = 1;
            else if (eclr)           m_ovr = 0;
            if (re && n == 0)        m_unr = 1;
            else if (eclr)           m_unr = 0;
        end
    endtask

    task automatic step(input bit we, input bit re, input logic [7:0] di,
                        input bit clr, input bit eclr);
        WE = we; RE = re; DI = di; Clr = clr; ErrClr = eclr;
        if (!clr && re && mq.size() > 0) exp_q.push_back(mq[0]);
        @(posedge Clk);
        model_edge(we, re, di, clr, eclr);
        #1;
        WE = 0; RE = 0; Clr = 0; ErrClr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
    endtask

    // Monitor: status every cycle, data whenever the DUT presents a word being popped
    always @(negedge Clk) begin
        int n;
        logic [7:0] e;
        n = mq.size();
        chk("count", int'(Count), n);
        chk("ef", int'(EF), int'(n == 0));
        chk("ff", int'(FF), int'(n == D));
        chk("hf", int'(HF), int'(n >= D / 2));
        chk("tf", int'(TF), int'((Thr != 0) && (n >= int'(Thr))));
        chk("ovr", int'(OVR), int'(m_ovr));
        chk("unr", int'(UNR), int'(m_unr));
        chk("irq", int'(IRQ), int'(m_irq));
        if (Rst && RE && !Clr && !EF) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL do_pop: got %0d expected no word available", DO);
            end else begin
                e = exp_q.pop_front();
                chk("do", int'(DO), int'(e));
            end
        end
    end

    initial begin
        Rst = 0; Clr = 0; WE = 0; RE = 0; DI = 0; ErrClr = 0; Thr = 0; IrqEn = 0;
        #2;
        chk("rst_count", int'(Count), 0);
        chk("rst_ef", int'(EF), 1);
        chk("rst_irq", int'(IRQ), 0);
        @(posedge Clk); #1 Rst = 1;

        // Fill and drain
        for (int i = 0; i < D; i++) step(1, 0, 8'(i), 0, 0);
        for (int i = 0; i < D; i++) step(0, 1, 8'h00, 0, 0);

        // Overflow, concurrent access at full, ErrClr
        for (int i = 0; i < D; i++) step(1, 0, 8'(8'h10 + i), 0, 0);
        step(1, 0, 8'hAA, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < D; i++) step(0, 1, 8'h00, 0, 0);

        // Underflow on empty with a concurrent write
        step(1, 1, 8'h3C, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1);

        // Threshold interrupt
        Thr = 5; IrqEn = 4'b0100;
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
        idle(2);
        Thr = 0;
        idle(2);
        Thr = 16;
        for (int i = 0; i < 11; i++) step(1, 0, 8'(8'h50 + i), 0, 0);
        idle(2);
        for (int i = 0; i < D; i++) step(0, 1, 8'h00, 0, 0);
        Thr = 0; IrqEn = 0;

        // Wrap-around with occupancy held at 3
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h70 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);

        // Clear with a concurrent write, then asynchronous reset mid-operation
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'hA0 + i), 0, 0);
        step(1, 0, 8'hEE, 1, 0);
        Thr = 2; IrqEn = 4'b0100;
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hB0 + i), 0, 0);
        #1 Rst = 0;
        #1;
        chk("arst_count", int'(Count), 0);
        chk("arst_ef", int'(EF), 1);
        chk("arst_irq", int'(IRQ), 0);
        mq.delete(); exp_q.delete();
        m_ovr = 0; m_unr = 0; m_irq = 0;
        @(posedge Clk); #1 Rst = 1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit we, re;
            if (($urandom_range(0, 29)) == 0) Thr = 5'($urandom_range(0, 16));
            if (($urandom_range(0, 29)) == 0) IrqEn = 4'($urandom);
            if (((i / 100) % 2) == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            step(we, re, 8'($urandom), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 19) == 0));
        end
        idle(2);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ssp_uart_fifo.md
# ssp_uart_fifo

Parametrised synchronous FIFO with occupancy, threshold and error status and a maskable interrupt. It is the next-generation transmit/receive buffer behind the SSP UART TDR/RDR registers. It generalises the fixed UART FIFOs in data width and depth, and adds:

- a programmable fill threshold,
- sticky overflow/underflow flags,
- an occupancy count readable through USR.

One instance sits on the transmit path and one on the receive path.

## Interface
Parameters:
- DW, 8, data width in bits (1..12; 12 matches the SSP data bus)
- AW, 4, address width; depth D = 2**AW (AW ≥ 1)

Ports:
- Clk  in  1  system clock; all state changes on its rising edge
- Rst  in  1  asynchronous, active-low reset
- Clr  in  1  synchronous FIFO clear (the TFC/RFC register bit)
- WE  in  1  write strobe; pushes DI
- DI  in  DW  write data
- RE  in  1  read strobe; pops the head word
- DO  out  DW  head word, first-word-fall-through; valid while EF=0
- Thr  in  AW+1  fill threshold, 0..D; 0 disables TF
- Count  out  AW+1  current occupancy, 0..D
- EF  out  1  empty (Count==0)
- FF  out  1  full (Count==D)
- HF  out  1  half full (Count ≥ D/2)
- TF  out  1  threshold reached (Thr≠0 and Count ≥ Thr)
- OVR  out  1  sticky overflow
- UNR  out  1  sticky underflow
- ErrClr  in  1  clears OVR and UNR
- IrqEn  in  4  interrupt enables {err, TF, HF, EF}
- IRQ  out  1  registered interrupt request

## Operation
Storage:
- D×DW register array.
- Write pointer wp and read pointer rp, each AW bits, wrapping modulo D.
- Count register, AW+1 bits.

Per-edge priority, highest first:
1. Clr=1: wp=rp=Count=0, OVR=UNR=0. WE, RE and ErrClr are ignored that cycle. Array contents are don't-care.
2. Otherwise, the write and the read are evaluated independently against the pre-edge Count:
   - Write accepted if WE=1 and (Count<D, or Count==D with RE=1). An accepted write stores mem[wp]=DI and increments wp.
   - WE=1 with Count==D and RE=0: write dropped, OVR set.
   - Read accepted if RE=1 and Count>0. An accepted read increments rp.
   - RE=1 with Count==0: read ignored, UNR set. This holds even when WE=1 in the same cycle; the write is still accepted.
   - Count changes by +1 for write only, −1 for read only, and is unchanged when both are accepted.
3. ErrClr=1: OVR and UNR cleared. A new error in the same cycle wins (the flag stays or becomes 1).

Outputs:
- EF, FF, HF and TF are combinational decodes of the registered Count and Thr. There is no extra register stage.
- DO = mem[rp] (combinational read). DO is don't-care while EF=1.
- IRQ is registered each edge as |(IrqEn & {OVR|UNR, TF, HF, EF}), using pre-edge values. Clr forces IRQ to 0 on that edge.
- Thr may change at any time. TF follows it combinationally.

Reset values (Rst=0, asynchronous):
- Count=0, wp=rp=0, EF=1, FF=0, HF=0, TF=0, OVR=0, UNR=0, IRQ=0.
- DO is don't-care. The array is not reset.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Write latency: data written at edge k appears on DO after edge k if the FIFO was empty. EF falls and Count increments after edge k.
- Read latency: zero (FWFT). DO shows the head word before RE is asserted. The next word is presented after the popping edge.
- Flags (EF, FF, HF, TF) update in the same cycle as Count. OVR and UNR are set on the edge of the offending strobe.
- IRQ asserts one edge after the enabled source becomes true. It deasserts one edge after the source clears, or on the Clr edge.
- Strobes are level-sampled each edge. Holding WE or RE for N cycles performs N operations.
- Rst release is synchronised by the integrator. This block samples its first strobes on the first rising edge after Rst goes high.

## Test plan
All cases use DW=8, AW=4 (D=16) unless stated.
- Fill/drain: write 0x00..0x0F on 16 consecutive edges → FF=1, Count=16, HF=1 from the 8th write. Then 16 reads → DO sequence 0x00..0x0F, EF=1, Count=0.
- Overflow and concurrent access at full: with the FIFO full, WE=1, RE=0, DI=0xAA → OVR=1, Count=16, data unchanged. Then WE=RE=1, DI=0x55 → Count=16, head advances, 0x55 is the last word read out. ErrClr → OVR=0.
- Underflow on empty: RE=1 with WE=1, DI=0x3C → UNR=1, Count=1, DO=0x3C. Then RE=1 alone → UNR stays 1, Count=0.
- Threshold interrupt: Thr=5, IrqEn=4'b0100; write 5 words → TF=1 after the 5th edge, IRQ=1 one edge later. Set Thr=0 → TF=0, IRQ=0 one edge later. Repeat with Thr=16 → TF only when FF.
- Wrap-around: 40 interleaved write/read pairs with occupancy held at 3 → data order preserved across pointer wrap, Count stays 3, no OVR/UNR.
- Clear and reset mid-operation: with 7 words stored, Clr with WE=1 → Count=0, EF=1, written word discarded. Refill 4 words, pulse Rst low between edges → Count=0, EF=1, IRQ=0 immediately, before the next edge.
